// File: rtl/host_loader.sv
// Host-side command sequencer in front of the CPU external port.
// It parses header+payload frames and turns them into cache loads, readbacks and timed CPU runs.
module host_loader #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        cpu_reset,
  output logic [1:0]  cpu_cmd,
  output logic [31:0] cpu_addr,
  output logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ_WAIT, S_READ_OUT, S_RUN} state_t;

  localparam logic [1:0] CMD_REG  = 2'b00;
  localparam logic [1:0] CMD_IWR  = 2'b01;
  localparam logic [1:0] CMD_DRD  = 2'b10;
  localparam logic [1:0] CMD_DWR  = 2'b11;
  localparam int         LAT_W    = $clog2(READ_LAT + 2);

  state_t             r_state, w_state_nxt;
  logic [12:0]        r_cnt, w_cnt_nxt;
  logic [15:0]        r_addr, w_addr_nxt;
  logic               r_is_imem, w_is_imem_nxt;
  logic [LAT_W-1:0]   r_lat, w_lat_nxt;
  logic [28:0]        r_run, w_run_nxt;
  logic               r_cpu_reset, w_cpu_reset_nxt;
  logic [1:0]         r_cpu_cmd, w_cpu_cmd_nxt;
  logic [31:0]        r_cpu_addr, w_cpu_addr_nxt;
  logic [31:0]        r_cpu_wdata, w_cpu_wdata_nxt;
  logic               r_m_valid, w_m_valid_nxt;
  logic [31:0]        r_m_data, w_m_data_nxt;
  logic               r_busy, r_err, w_err_nxt;

  logic [2:0]  w_op;
  logic [12:0] w_cnt_hdr;
  logic [15:0] w_base;
  logic [28:0] w_cycles;
  logic        w_s_fire;
  logic [15:0] w_addr_inc;

  assign w_op      = s_data[31:29];
  assign w_cnt_hdr = s_data[28:16];
  assign w_base    = {s_data[15:2], 2'b00};
  assign w_cycles  = s_data[28:0];

  assign s_ready   = !reset && (r_state == S_IDLE || r_state == S_WRITE);
  assign w_s_fire  = s_valid && s_ready;

  // Register indices wrap mod 32, memory byte addresses wrap mod 2^16.
  assign w_addr_inc = (r_cpu_cmd == CMD_REG) ? {11'b0, r_addr[4:0] + 5'd1} : r_addr + 16'd4;

  // NOTE: every signal gets its default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_is_imem_nxt   = r_is_imem;
    w_lat_nxt       = r_lat;
    w_run_nxt       = r_run;
    w_cpu_reset_nxt = 1'b1;
    w_cpu_cmd_nxt   = CMD_DRD;
    w_cpu_addr_nxt  = r_cpu_addr;
    w_cpu_wdata_nxt = r_cpu_wdata;
    w_m_valid_nxt   = r_m_valid;
    w_m_data_nxt    = r_m_data;
    w_err_nxt       = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (w_s_fire) begin
          unique case (w_op)
            3'b001, 3'b011: if (w_cnt_hdr != 13'd0) begin
              w_state_nxt   = S_WRITE;
              w_cnt_nxt     = w_cnt_hdr;
              w_addr_nxt    = w_base;
              w_is_imem_nxt = (w_op == 3'b001);
            end
            3'b010: if (w_cnt_hdr != 13'd0) begin
              w_state_nxt    = S_READ_WAIT;
              w_cnt_nxt      = w_cnt_hdr;
              w_addr_nxt     = w_base;
              w_lat_nxt      = '0;
              w_cpu_addr_nxt = {16'b0, w_base};
            end
            3'b000: if (w_cnt_hdr != 13'd0) begin
              w_state_nxt    = S_READ_WAIT;
              w_cnt_nxt      = w_cnt_hdr;
              w_addr_nxt     = {11'b0, s_data[4:0]};
              w_lat_nxt      = '0;
              w_cpu_cmd_nxt  = CMD_REG;
              w_cpu_addr_nxt = {27'b0, s_data[4:0]};
            end
            3'b100: if (w_cycles != 29'd0) begin
              w_state_nxt     = S_RUN;
              w_run_nxt       = w_cycles;
              w_cpu_reset_nxt = 1'b0;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      S_WRITE: begin
        if (w_s_fire) begin
          w_cpu_cmd_nxt   = r_is_imem ? CMD_IWR : CMD_DWR;
          w_cpu_addr_nxt  = {16'b0, r_addr};
          w_cpu_wdata_nxt = s_data;
          w_addr_nxt      = r_addr + 16'd4;
          w_cnt_nxt       = r_cnt - 13'd1;
          if (r_cnt == 13'd1) w_state_nxt = S_IDLE;
        end
      end
      S_READ_WAIT: begin
        w_cpu_cmd_nxt = r_cpu_cmd;
        if (r_lat == LAT_W'(READ_LAT)) begin
          w_m_valid_nxt = 1'b1;
          w_m_data_nxt  = cpu_rdata;
          w_state_nxt   = S_READ_OUT;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      S_READ_OUT: begin
        w_cpu_cmd_nxt = r_cpu_cmd;
        if (m_ready) begin
          w_m_valid_nxt = 1'b0;
          if (r_cnt == 13'd1) begin
            w_state_nxt   = S_IDLE;
            w_cpu_cmd_nxt = CMD_DRD;
          end else begin
            w_cnt_nxt      = r_cnt - 13'd1;
            w_addr_nxt     = w_addr_inc;
            w_cpu_addr_nxt = {16'b0, w_addr_inc};
            w_lat_nxt      = '0;
            w_state_nxt    = S_READ_WAIT;
          end
        end
      end
      S_RUN: begin
        if (r_run == 29'd1) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cpu_reset_nxt = 1'b0;
          w_run_nxt       = r_run - 29'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_is_imem   <= 1'b0;
      r_lat       <= '0;
      r_run       <= '0;
      r_cpu_reset <= 1'b1;
      r_cpu_cmd   <= CMD_DRD;
      r_cpu_addr  <= '0;
      r_cpu_wdata <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_is_imem   <= w_is_imem_nxt;
      r_lat       <= w_lat_nxt;
      r_run       <= w_run_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_cpu_cmd   <= w_cpu_cmd_nxt;
      r_cpu_addr  <= w_cpu_addr_nxt;
      r_cpu_wdata <= w_cpu_wdata_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_data    <= w_m_data_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_err       <= w_err_nxt;
    end
  end

  assign cpu_reset = r_cpu_reset;
  assign cpu_cmd   = r_cpu_cmd;
  assign cpu_addr  = r_cpu_addr;
  assign cpu_wdata = r_cpu_wdata;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_host_loader.sv
// Directed bench for host_loader: a registered-read CPU port model answers readbacks,
// and each step checks outputs on the falling edge against hand-computed values.
module tb_host_loader;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_ready, m_valid, m_ready, cpu_reset, busy, err;
  logic [31:0] s_data, m_data, cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_cmd;

  int n_tests = 0;
  int n_fail  = 0;

  host_loader #(.READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .cpu_reset(cpu_reset), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_f(input logic [1:0] cmd, input logic [31:0] addr);
    if (cmd == 2'b00)      return 32'hA5A5_0000 | addr;
    else if (cmd == 2'b10) return 32'h5A5A_0000 ^ addr;
    else                   return 32'hDEAD_BEEF;
  endfunction

  // One-cycle read latency, like a BRAM port with a registered output.
  always @(posedge clk) cpu_rdata <= rd_f(cpu_cmd, cpu_addr);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_mvalid(input string tag);
    for (int i = 0; i < 20 && m_valid !== 1'b1; i++) tick();
    chk(tag, 32'(m_valid), 32'd1);
  endtask

  task automatic send(input logic [31:0] word);
    s_valid = 1'b1;
    s_data  = word;
    tick();
  endtask

  int low_cnt;
  int bad_cnt;

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) tick();
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_cmd",   32'(cpu_cmd),   32'd2);
    chk("rst_cpu_addr",  cpu_addr,       32'd0);
    chk("rst_cpu_wdata", cpu_wdata,      32'd0);
    chk("rst_m_valid",   32'(m_valid),   32'd0);
    chk("rst_m_data",    m_data,         32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_s_ready",   32'(s_ready),   32'd0);
    reset = 1'b0;
    #1 chk("idle_s_ready", 32'(s_ready), 32'd1);

    // 1: three-word I-cache load, back to back
    send(32'h2003_0010);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_cmd_hdr", 32'(cpu_cmd), 32'd2);
    send(32'h0000_000A);
    chk("t1_cmd0", 32'(cpu_cmd), 32'd1);
    chk("t1_addr0", cpu_addr, 32'h10);
    chk("t1_data0", cpu_wdata, 32'hA);
    send(32'h0000_000B);
    chk("t1_cmd1", 32'(cpu_cmd), 32'd1);
    chk("t1_addr1", cpu_addr, 32'h14);
    chk("t1_data1", cpu_wdata, 32'hB);
    send(32'h0000_000C);
    chk("t1_cmd2", 32'(cpu_cmd), 32'd1);
    chk("t1_addr2", cpu_addr, 32'h18);
    chk("t1_data2", cpu_wdata, 32'hC);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd1);
    s_valid = 1'b0;
    tick();
    chk("t1_cmd_back", 32'(cpu_cmd), 32'd2);

    // 2: two-word D-cache read with backpressure
    send(32'h4002_0100);
    s_valid = 1'b0;
    wait_mvalid("t2_mvalid0");
    chk("t2_data0", m_data, rd_f(2'b10, 32'h100));
    chk("t2_cmd0", 32'(cpu_cmd), 32'd2);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_s_ready", 32'(s_ready), 32'd0);
    repeat (5) begin
      tick();
      chk("t2_hold_valid", 32'(m_valid), 32'd1);
      chk("t2_hold_data", m_data, rd_f(2'b10, 32'h100));
      chk("t2_hold_addr", cpu_addr, 32'h100);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t2_drop_valid", 32'(m_valid), 32'd0);
    wait_mvalid("t2_mvalid1");
    chk("t2_data1", m_data, rd_f(2'b10, 32'h104));
    chk("t2_addr1", cpu_addr, 32'h104);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_mvalid_off", 32'(m_valid), 32'd0);

    // 3: register readback wrapping 31 -> 0
    send(32'h0002_001F);
    s_valid = 1'b0;
    chk("t3_cmd_a", 32'(cpu_cmd), 32'd0);
    wait_mvalid("t3_mvalid0");
    chk("t3_data0", m_data, rd_f(2'b00, 32'd31));
    chk("t3_addr0", cpu_addr, 32'd31);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t3_cmd_b", 32'(cpu_cmd), 32'd0);
    wait_mvalid("t3_mvalid1");
    chk("t3_data1", m_data, rd_f(2'b00, 32'd0));
    chk("t3_addr1", cpu_addr, 32'd0);
    chk("t3_cmd_c", 32'(cpu_cmd), 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: run for 100 cycles
    send(32'h8000_0064);
    s_valid = 1'b0;
    low_cnt = 0;
    bad_cnt = 0;
    for (int i = 0; i < 200 && cpu_reset === 1'b0; i++) begin
      if (s_ready !== 1'b0 || busy !== 1'b1 || cpu_cmd !== 2'b10) bad_cnt++;
      low_cnt++;
      tick();
    end
    chk("t4_low_cycles", low_cnt, 100);
    chk("t4_run_flags", bad_cnt, 0);
    chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: unknown opcode, then a one-word D-cache write
    send(32'hE000_0000);
    s_valid = 1'b0;
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cmd", 32'(cpu_cmd), 32'd2);
    send(32'h6001_0000);
    send(32'h0000_0005);
    chk("t5_wcmd", 32'(cpu_cmd), 32'd3);
    chk("t5_waddr", cpu_addr, 32'h0);
    chk("t5_wdata", cpu_wdata, 32'h5);
    s_valid = 1'b0;
    tick();
    chk("t5_cmd_back", 32'(cpu_cmd), 32'd2);
    chk("t5_err_sticky", 32'(err), 32'd1);

    // empty frame and D-cache address wrap at 0xFFFC
    send(32'h2000_0000);
    s_valid = 1'b0;
    chk("cnt0_idle", 32'(busy), 32'd0);
    send(32'h6002_FFFC);
    send(32'h0000_0001);
    chk("wrap_addr0", cpu_addr, 32'hFFFC);
    send(32'h0000_0002);
    chk("wrap_addr1", cpu_addr, 32'h0000);
    chk("wrap_data1", cpu_wdata, 32'h2);
    s_valid = 1'b0;

    // 6: reset in the middle of a three-word write
    send(32'h2003_0040);
    send(32'h0000_0011);
    chk("t6_cmd0", 32'(cpu_cmd), 32'd1);
    chk("t6_addr0", cpu_addr, 32'h40);
    s_valid = 1'b0;
    reset = 1'b1;
    #1 chk("t6_sready_rst", 32'(s_ready), 32'd0);
    tick();
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cmd", 32'(cpu_cmd), 32'd2);
    chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6_err_cleared", 32'(err), 32'd0);
    send(32'h6001_0023);
    chk("t6_hdr_busy", 32'(busy), 32'd1);
    send(32'h0000_0077);
    chk("t6_wcmd", 32'(cpu_cmd), 32'd3);
    chk("t6_waddr", cpu_addr, 32'h20);
    chk("t6_wdata", cpu_wdata, 32'h77);
    s_valid = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
